// File: rtl/regfile_mp_pkg.sv
// Shared defaults for the multi-port register file and its storage entries.
package regfile_mp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_READ   = 2;
  localparam int DEF_NUM_WRITE  = 2;

  // A one-bit address is still needed when the file holds only two registers.
  function automatic int addrWidthFor(input int numRegs);
    return (numRegs <= 2) ? 1 : $clog2(numRegs);
  endfunction

endpackage

// File: rtl/regfile_mp_entry.sv
// One architectural register with its scoreboard pending bit.
module regfile_mp_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  setPending,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  pending
);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      value   <= '0;
      pending <= 1'b0;
    end else begin
      if (writeEnable) value <= writeData;
      // A fresh issue means a newer producer is outstanding, so it beats the clear.
      if (setPending)       pending <= 1'b1;
      else if (writeEnable) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// N-read / M-write register file with optional zero register, write-to-read bypass
// and per-register pending bits for the issue scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = addrWidthFor(NUM_REGS),
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic [NUM_WRITE-1:0]             ctrl_writeEnable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  ctrl_writeReg,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0]   data_readReg,
  output logic [NUM_READ-1:0]              data_readPending,
  input  logic                             ctrl_issueEnable,
  input  logic [ADDR_WIDTH-1:0]            ctrl_issueReg
);

  logic [DATA_WIDTH-1:0] regValue     [NUM_REGS];
  logic [DATA_WIDTH-1:0] regWriteData [NUM_REGS];
  logic [NUM_REGS-1:0]   regPending;
  logic [NUM_REGS-1:0]   regWrite;
  logic [NUM_REGS-1:0]   regIssue;

  // Addresses that name a real, writable register.
  function automatic logic isLive(input logic [ADDR_WIDTH-1:0] addr);
    return (int'(addr) < NUM_REGS) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
  always_comb begin
    regWrite = '0;
    regIssue = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regWriteData[r] = '0;
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (ctrl_writeEnable[k] && (ctrl_writeReg[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
            && isLive(ADDR_WIDTH'(r))) begin
          regWrite[r]     = 1'b1;
          regWriteData[r] = data_writeReg[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      regIssue[r] = ctrl_issueEnable && (ctrl_issueReg == ADDR_WIDTH'(r)) && isLive(ADDR_WIDTH'(r));
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : gEntry
    regfile_mp_entry #(
      .DATA_WIDTH (DATA_WIDTH)
    ) uEntry (
      .clock       (clock),
      .resetN      (ctrl_reset),
      .writeEnable (regWrite[r]),
      .writeData   (regWriteData[r]),
      .setPending  (regIssue[r]),
      .value       (regValue[r]),
      .pending     (regPending[r])
    );
  end

  always_comb begin : readMux
    logic [ADDR_WIDTH-1:0] readAddr;
    logic [DATA_WIDTH-1:0] readData;
    logic [DATA_WIDTH-1:0] bypassData;
    logic                  readPend;
    logic                  bypassHit;
    data_readReg     = '0;
    data_readPending = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      readAddr   = ctrl_readReg[j*ADDR_WIDTH +: ADDR_WIDTH];
      readData   = '0;
      readPend   = 1'b0;
      bypassData = '0;
      bypassHit  = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (readAddr == ADDR_WIDTH'(r)) begin
          readData = regValue[r];
          readPend = regPending[r];
        end
      end
      // Forwarding is held off during reset so every port reads the cleared state.
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (ctrl_reset && ctrl_writeEnable[k] && isLive(readAddr)
            && (ctrl_writeReg[k*ADDR_WIDTH +: ADDR_WIDTH] == readAddr)) begin
          bypassHit  = 1'b1;
          bypassData = data_writeReg[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if ((BYPASS != 0) && bypassHit) begin
        readData = bypassData;
        readPend = 1'b0;
      end
      data_readReg[j*DATA_WIDTH +: DATA_WIDTH] = readData;
      data_readPending[j]                      = readPend;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic against a plain array model.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int NRB = 16;
  localparam int AWB = 4;
  localparam int NRDB = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstN;
  logic [NWR-1:0]     wen;
  logic [NWR*AW-1:0]  waddr;
  logic [NWR*DW-1:0]  wdata;
  logic [NRD*AW-1:0]  raddr;
  logic [NRD*DW-1:0]  rdata;
  logic [NRD-1:0]     rpend;
  logic               issue;
  logic [AW-1:0]      issueReg;

  logic [NWR-1:0]      wenB;
  logic [NWR*AWB-1:0]  waddrB;
  logic [NWR*DW-1:0]   wdataB;
  logic [NRDB*AWB-1:0] raddrB;
  logic [NRDB*DW-1:0]  rdataB;
  logic [NRDB-1:0]     rpendB;
  logic                issueB;
  logic [AWB-1:0]      issueRegB;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] memA [NR];
  logic          pendA [NR];
  logic [DW-1:0] memB [NRB];
  logic          pendB [NRB];

  regfile_mp dutA (
    .clock(clock), .ctrl_reset(rstN), .ctrl_writeEnable(wen), .ctrl_writeReg(waddr),
    .data_writeReg(wdata), .ctrl_readReg(raddr), .data_readReg(rdata),
    .data_readPending(rpend), .ctrl_issueEnable(issue), .ctrl_issueReg(issueReg)
  );

  regfile_mp #(.NUM_REGS(NRB), .ADDR_WIDTH(AWB), .NUM_READ(NRDB), .BYPASS(0)) dutB (
    .clock(clock), .ctrl_reset(rstN), .ctrl_writeEnable(wenB), .ctrl_writeReg(waddrB),
    .data_writeReg(wdataB), .ctrl_readReg(raddrB), .data_readReg(rdataB),
    .data_readPending(rpendB), .ctrl_issueEnable(issueB), .ctrl_issueReg(issueRegB)
  );

  // Reference model: register 0 is hardwired, so only 1..N-1 hold state.
  function automatic logic liveA(int a); return (a > 0) && (a < NR); endfunction
  function automatic logic liveB(int a); return (a > 0) && (a < NRB); endfunction

  function automatic logic [DW-1:0] expDataA(int a);
    logic [DW-1:0] d;
    if (!rstN || !liveA(a)) return '0;
    d = memA[a];
    for (int k = 0; k < NWR; k++)
      if (wen[k] && int'(waddr[k*AW +: AW]) == a) d = wdata[k*DW +: DW];
    return d;
  endfunction

  function automatic logic expPendA(int a);
    logic p;
    if (!rstN || !liveA(a)) return 1'b0;
    p = pendA[a];
    for (int k = 0; k < NWR; k++)
      if (wen[k] && int'(waddr[k*AW +: AW]) == a) p = 1'b0;
    return p;
  endfunction

  function automatic logic [DW-1:0] expDataB(int a);
    return (rstN && liveB(a)) ? memB[a] : '0;
  endfunction

  function automatic logic expPendB(int a);
    return (rstN && liveB(a)) ? pendB[a] : 1'b0;
  endfunction

  task automatic clearModel();
    for (int r = 0; r < NR; r++) begin memA[r] = '0; pendA[r] = 1'b0; end
    for (int r = 0; r < NRB; r++) begin memB[r] = '0; pendB[r] = 1'b0; end
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; issue = 1'b0; issueReg = '0;
    wenB = '0; waddrB = '0; wdataB = '0; issueB = 1'b0; issueRegB = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven, then step the DUT.
  task automatic tick();
    if (rstN) begin
      for (int k = 0; k < NWR; k++) begin
        if (wen[k] && liveA(int'(waddr[k*AW +: AW]))) begin
          memA[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
          pendA[waddr[k*AW +: AW]] = 1'b0;
        end
        if (wenB[k] && liveB(int'(waddrB[k*AWB +: AWB]))) begin
          memB[waddrB[k*AWB +: AWB]] = wdataB[k*DW +: DW];
          pendB[waddrB[k*AWB +: AWB]] = 1'b0;
        end
      end
      if (issue && liveA(int'(issueReg))) pendA[issueReg] = 1'b1;
      if (issueB && liveB(int'(issueRegB))) pendB[issueRegB] = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int r = 0; r < NR; r++) begin
      raddr = {AW'(r), AW'(r)};
      #1;
      checks++;
      if (rdata !== '0 || rpend !== '0) begin
        failures++;
        $display("FAIL reset_init r%0d data=%h pend=%b exp data=0 pend=0", r, rdata, rpend);
      end
    end
    wen = 2'b01; waddr = {AW'(0), AW'(5)}; wdata = {32'h0, 32'hDEADBEEF};
    issue = 1'b1; issueReg = AW'(6);
    tick();
    idle();
    raddr = {AW'(6), AW'(5)};
    #1;
    checks++;
    if (rdata[31:0] !== 32'hDEADBEEF || rpend !== 2'b10) begin
      failures++;
      $display("FAIL reset_prewrite data=%h pend=%b exp data=deadbeef pend=10", rdata[31:0], rpend);
    end
    rstN = 1'b0;
    clearModel();
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      failures++;
      $display("FAIL reset_async data=%h pend=%b exp data=0 pend=0", rdata, rpend);
    end
    wen = 2'b01; waddr = {AW'(0), AW'(5)}; wdata = {32'h0, 32'h11112222};
    issue = 1'b1; issueReg = AW'(5);
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      failures++;
      $display("FAIL reset_nobypass data=%h pend=%b exp data=0 pend=0", rdata, rpend);
    end
    tick();
    idle();
    #2;
    rstN = 1'b1;
    tick();
    for (int r = 0; r < NR; r++) begin
      raddr = {AW'(r), AW'(r)};
      #1;
      checks++;
      if (rdata !== '0 || rpend !== '0) begin
        failures++;
        $display("FAIL reset_after r%0d data=%h pend=%b exp data=0 pend=0", r, rdata, rpend);
      end
    end
  endtask

  task automatic test_write_read();
    wen = 2'b01; waddr = {AW'(0), AW'(7)}; wdata = {32'h0, 32'h12345678};
    tick();
    idle();
    raddr = {AW'(7), AW'(7)};
    #1;
    checks++;
    if (rdata !== {32'h12345678, 32'h12345678} || rpend !== 2'b00) begin
      failures++;
      $display("FAIL write_read data=%h pend=%b exp data=12345678x2 pend=00", rdata, rpend);
    end
  endtask

  task automatic test_conflict();
    wen = 2'b11; waddr = {AW'(3), AW'(3)}; wdata = {32'h0000BBBB, 32'hAAAA0000};
    raddr = {AW'(7), AW'(3)};
    #1;
    checks++;
    if (rdata[31:0] !== 32'h0000BBBB || rdata[63:32] !== 32'h12345678) begin
      failures++;
      $display("FAIL conflict_bypass data=%h exp rp0=0000bbbb rp1=12345678", rdata);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata[31:0] !== 32'h0000BBBB) begin
      failures++;
      $display("FAIL conflict_stored data=%h exp=0000bbbb", rdata[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    issue = 1'b1; issueReg = AW'(9);
    tick();
    idle();
    raddr = {AW'(9), AW'(0)};
    #1;
    checks++;
    if (rpend[1] !== 1'b1) begin
      failures++;
      $display("FAIL sb_issue pend=%b exp=1", rpend[1]);
    end
    wen = 2'b01; waddr = {AW'(0), AW'(9)}; wdata = {32'h0, 32'h55};
    #1;
    checks++;
    if (rpend[1] !== 1'b0 || rdata[63:32] !== 32'h55) begin
      failures++;
      $display("FAIL sb_bypass pend=%b data=%h exp pend=0 data=55", rpend[1], rdata[63:32]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rpend[1] !== 1'b0 || rdata[63:32] !== 32'h55) begin
      failures++;
      $display("FAIL sb_cleared pend=%b data=%h exp pend=0 data=55", rpend[1], rdata[63:32]);
    end
    wen = 2'b10; waddr = {AW'(9), AW'(0)}; wdata = {32'h66, 32'h0};
    issue = 1'b1; issueReg = AW'(9);
    tick();
    idle();
    #1;
    checks++;
    if (rpend[1] !== 1'b1 || rdata[63:32] !== 32'h66) begin
      failures++;
      $display("FAIL sb_setwins pend=%b data=%h exp pend=1 data=66", rpend[1], rdata[63:32]);
    end
  endtask

  task automatic test_zero_reg();
    wen = 2'b01; waddr = {AW'(0), AW'(0)}; wdata = {32'h0, 32'hFFFFFFFF};
    issue = 1'b1; issueReg = AW'(0);
    raddr = {AW'(0), AW'(0)};
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      failures++;
      $display("FAIL zero_during data=%h pend=%b exp data=0 pend=0", rdata, rpend);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata !== '0 || rpend !== '0) begin
      failures++;
      $display("FAIL zero_after data=%h pend=%b exp data=0 pend=0", rdata, rpend);
    end
  endtask

  task automatic test_params();
    wenB = 2'b01; waddrB = {AWB'(0), AWB'(15)}; wdataB = {32'h0, 32'h1};
    raddrB = {AWB'(15), AWB'(0), AWB'(0)};
    #1;
    checks++;
    if (rdataB[95:64] !== 32'h0) begin
      failures++;
      $display("FAIL params_nobypass data=%h exp=0", rdataB[95:64]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdataB[95:64] !== 32'h1) begin
      failures++;
      $display("FAIL params_after data=%h exp=1", rdataB[95:64]);
    end
    for (int r = 1; r < NRB; r += 2) begin
      wenB = 2'b11;
      waddrB = {AWB'(r + 1), AWB'(r)};
      wdataB = {32'h100 + 32'(r + 1), 32'h100 + 32'(r)};
      if (r + 1 >= NRB) wenB = 2'b01;
      tick();
    end
    idle();
    for (int r = 0; r < NRB; r++) begin
      raddrB = {AWB'(r), AWB'((r + 5) % NRB), AWB'((r + 11) % NRB)};
      #1;
      for (int j = 0; j < NRDB; j++) begin
        checks++;
        if (rdataB[j*DW +: DW] !== expDataB(int'(raddrB[j*AWB +: AWB]))) begin
          failures++;
          $display("FAIL params_indep port%0d addr=%0d data=%h exp=%h", j,
                   raddrB[j*AWB +: AWB], rdataB[j*DW +: DW], expDataB(int'(raddrB[j*AWB +: AWB])));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wen = NWR'($urandom);
      for (int k = 0; k < NWR; k++) begin
        waddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(3) : AW'($urandom_range(0, NR - 1));
        wdata[k*DW +: DW] = $urandom;
        waddrB[k*AWB +: AWB] = AWB'($urandom_range(0, NRB - 1));
        wdataB[k*DW +: DW] = $urandom;
      end
      wenB = NWR'($urandom);
      issue = 1'($urandom); issueReg = AW'($urandom_range(0, NR - 1));
      issueB = 1'($urandom); issueRegB = AWB'($urandom_range(0, NRB - 1));
      for (int j = 0; j < NRD; j++)
        raddr[j*AW +: AW] = $urandom_range(0, 1) ? waddr[$urandom_range(0, NWR - 1)*AW +: AW]
                                                  : AW'($urandom_range(0, NR - 1));
      for (int j = 0; j < NRDB; j++)
        raddrB[j*AWB +: AWB] = AWB'($urandom_range(0, NRB - 1));
      #1;
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (rdata[j*DW +: DW] !== expDataA(int'(raddr[j*AW +: AW]))
            || rpend[j] !== expPendA(int'(raddr[j*AW +: AW]))) begin
          failures++;
          $display("FAIL rand_a n=%0d port%0d addr=%0d data=%h pend=%b exp data=%h pend=%b", n, j,
                   raddr[j*AW +: AW], rdata[j*DW +: DW], rpend[j],
                   expDataA(int'(raddr[j*AW +: AW])), expPendA(int'(raddr[j*AW +: AW])));
        end
      end
      for (int j = 0; j < NRDB; j++) begin
        checks++;
        if (rdataB[j*DW +: DW] !== expDataB(int'(raddrB[j*AWB +: AWB]))
            || rpendB[j] !== expPendB(int'(raddrB[j*AWB +: AWB]))) begin
          failures++;
          $display("FAIL rand_b n=%0d port%0d addr=%0d data=%h pend=%b exp data=%h pend=%b", n, j,
                   raddrB[j*AWB +: AWB], rdataB[j*DW +: DW], rpendB[j],
                   expDataB(int'(raddrB[j*AWB +: AWB])), expPendB(int'(raddrB[j*AWB +: AWB])));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    idle();
    raddr = '0;
    raddrB = '0;
    clearModel();
    @(posedge clock);
    @(posedge clock);
    #3;
    rstN = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_write_read();
    test_conflict();
    test_scoreboard();
    test_zero_reg();
    test_params();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
